// File: rtl/axi_ar_arbiter_router.sv
// rtl/axi_ar_arbiter_router.sv - AXI read-address arbiter/router, NUM_M masters to NUM_S slaves
// Optional macro AXI_AR_RR_ARB_EN selects round-robin arbitration; fixed priority otherwise.
module axi_ar_arbiter_router #(
  parameter int NUM_M     = 2,
  parameter int NUM_S     = 2,
  parameter int ID_BITS   = 4,
  parameter int MID_BITS  = 4,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3,
  parameter int SEL_LSB   = 16,
  parameter int MAX_OUTST = 4,
  localparam int IDS_BITS = MID_BITS + ID_BITS
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_M*ID_BITS-1:0]      ARID_M,
  input  logic [NUM_M*ADDR_BITS-1:0]    ARADDR_M,
  input  logic [NUM_M*LEN_BITS-1:0]     ARLEN_M,
  input  logic [NUM_M*SIZE_BITS-1:0]    ARSIZE_M,
  input  logic [NUM_M*2-1:0]            ARBURST_M,
  input  logic [NUM_M-1:0]              ARVALID_M,
  output logic [NUM_M-1:0]              ARREADY_M,
  input  logic [NUM_M-1:0]              RDONE_M,
  output logic [NUM_S*IDS_BITS-1:0]     ARID_S,
  output logic [NUM_S*ADDR_BITS-1:0]    ARADDR_S,
  output logic [NUM_S*LEN_BITS-1:0]     ARLEN_S,
  output logic [NUM_S*SIZE_BITS-1:0]    ARSIZE_S,
  output logic [NUM_S*2-1:0]            ARBURST_S,
  output logic [NUM_S-1:0]              ARVALID_S,
  input  logic [NUM_S-1:0]              ARREADY_S,
  output logic                          AR_DECERR,
  output logic [IDS_BITS-1:0]           AR_DECERR_ID
);

  localparam int MW   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SELW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
  localparam int CW   = 4;

  if (NUM_M > (1 << MID_BITS)) begin : g_cfg_check
    $error("axi_ar_arbiter_router: NUM_M exceeds 2**MID_BITS");
  end

  typedef enum logic [1:0] {IDLE, GRANT, UNMAP} state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   gnt_m_q, gnt_m_d;
  logic [SELW-1:0] gnt_s_q, gnt_s_d;
  logic [CW-1:0]   cnt_q [NUM_M];
  logic [CW-1:0]   cnt_d [NUM_M];
`ifdef AXI_AR_RR_ARB_EN
  logic [MW-1:0]   ptr_q, ptr_d;
`endif

  logic [NUM_M-1:0]    elig;
  logic [NUM_M-1:0]    inc;
  logic                win_valid;
  logic [MW-1:0]       win;
  logic [SELW-1:0]     win_sel;
  logic                win_unmapped;
  logic                hs;
  logic [IDS_BITS-1:0] comp_id;

  always_comb begin
    for (int i = 0; i < NUM_M; i++) begin
      elig[i] = ARVALID_M[i] && (cnt_q[i] < CW'(MAX_OUTST));
    end
  end

`ifdef AXI_AR_RR_ARB_EN
  // Search starts just after the last served master.
  always_comb begin
    int idx;
    idx       = 0;
    win_valid = 1'b0;
    win       = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      idx = (int'(ptr_q) + k) % NUM_M;
      if (!win_valid && elig[idx]) begin
        win_valid = 1'b1;
        win       = MW'(idx);
      end
    end
  end
`else
  always_comb begin
    win_valid = 1'b0;
    win       = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_valid = 1'b1;
        win       = MW'(i);
      end
    end
  end
`endif

  always_comb begin
    if (NUM_S > 1) win_sel = ARADDR_M[int'(win) * ADDR_BITS + SEL_LSB +: SELW];
    else           win_sel = '0;
    win_unmapped = (int'(win_sel) >= NUM_S);
  end

  assign hs      = ARVALID_M[gnt_m_q] && ARREADY_S[gnt_s_q];
  assign comp_id = {MID_BITS'(gnt_m_q), ARID_M[int'(gnt_m_q) * ID_BITS +: ID_BITS]};

  always_comb begin
    state_d = state_q;
    gnt_m_d = gnt_m_q;
    gnt_s_d = gnt_s_q;
    inc     = '0;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          gnt_m_d = win;
          gnt_s_d = win_sel;
          state_d = win_unmapped ? UNMAP : GRANT;
        end
      end
      GRANT: begin
        if (hs) begin
          inc[gnt_m_q] = 1'b1;
          state_d      = IDLE;
        end
      end
      UNMAP: begin
        inc[gnt_m_q] = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AXI_AR_RR_ARB_EN
  always_comb begin
    ptr_d = ptr_q;
    if (|inc) ptr_d = gnt_m_q;
  end
`endif

  // A completion in the same cycle as a new grant cancels out.
  always_comb begin
    for (int i = 0; i < NUM_M; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc[i] && !RDONE_M[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (!inc[i] && RDONE_M[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      gnt_m_q <= '0;
      gnt_s_q <= '0;
      for (int i = 0; i < NUM_M; i++) cnt_q[i] <= '0;
`ifdef AXI_AR_RR_ARB_EN
      ptr_q   <= MW'(NUM_M - 1);
`endif
    end else begin
      state_q <= state_d;
      gnt_m_q <= gnt_m_d;
      gnt_s_q <= gnt_s_d;
      for (int i = 0; i < NUM_M; i++) cnt_q[i] <= cnt_d[i];
`ifdef AXI_AR_RR_ARB_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  always_comb begin
    ARID_S       = '0;
    ARADDR_S     = '0;
    ARLEN_S      = '0;
    ARSIZE_S     = '0;
    ARBURST_S    = '0;
    ARVALID_S    = '0;
    ARREADY_M    = '0;
    AR_DECERR    = 1'b0;
    AR_DECERR_ID = '0;
    case (state_q)
      GRANT: begin
        ARID_S[int'(gnt_s_q) * IDS_BITS +: IDS_BITS]     = comp_id;
        ARADDR_S[int'(gnt_s_q) * ADDR_BITS +: ADDR_BITS] = ARADDR_M[int'(gnt_m_q) * ADDR_BITS +: ADDR_BITS];
        ARLEN_S[int'(gnt_s_q) * LEN_BITS +: LEN_BITS]    = ARLEN_M[int'(gnt_m_q) * LEN_BITS +: LEN_BITS];
        ARSIZE_S[int'(gnt_s_q) * SIZE_BITS +: SIZE_BITS] = ARSIZE_M[int'(gnt_m_q) * SIZE_BITS +: SIZE_BITS];
        ARBURST_S[int'(gnt_s_q) * 2 +: 2]                = ARBURST_M[int'(gnt_m_q) * 2 +: 2];
        ARVALID_S[gnt_s_q]                               = ARVALID_M[gnt_m_q];
        ARREADY_M[gnt_m_q]                               = ARREADY_S[gnt_s_q];
      end
      UNMAP: begin
        ARREADY_M[gnt_m_q] = 1'b1;
        AR_DECERR          = 1'b1;
        AR_DECERR_ID       = comp_id;
      end
      default: ;
    endcase
  end

endmodule
